// File: rtl/axi4lite_slave_regbank.sv
// AXI4-Lite slave exposing G_NB_REGS byte-strobed read/write registers.
// Independent write and read FSMs, all AXI outputs registered.
module axi4lite_slave_regbank #(
    parameter int G_AXI4_LITE_ADDR_WIDTH = 32,
    parameter int G_AXI4_LITE_DATA_WIDTH = 32,
    parameter int G_NB_REGS              = 16
) (
    input  logic                                     clk,
    input  logic                                     rst_n,
    input  logic                                     awvalid,
    input  logic [G_AXI4_LITE_ADDR_WIDTH-1:0]        awaddr,
    input  logic [2:0]                               awprot,
    output logic                                     awready,
    input  logic                                     wvalid,
    input  logic [G_AXI4_LITE_DATA_WIDTH-1:0]        wdata,
    input  logic [G_AXI4_LITE_DATA_WIDTH/8-1:0]      wstrb,
    output logic                                     wready,
    output logic                                     bvalid,
    output logic [1:0]                               bresp,
    input  logic                                     bready,
    input  logic                                     arvalid,
    input  logic [G_AXI4_LITE_ADDR_WIDTH-1:0]        araddr,
    input  logic [2:0]                               arprot,
    output logic                                     arready,
    output logic                                     rvalid,
    output logic [G_AXI4_LITE_DATA_WIDTH-1:0]        rdata,
    output logic [1:0]                               rresp,
    input  logic                                     rready,
    output logic [G_NB_REGS*G_AXI4_LITE_DATA_WIDTH-1:0] regs_o
);

    localparam int AW  = G_AXI4_LITE_ADDR_WIDTH;
    localparam int DW  = G_AXI4_LITE_DATA_WIDTH;
    localparam int SW  = DW / 8;
    localparam int OFS = $clog2(SW);
    localparam int IW  = AW - OFS;
    localparam logic [IW-1:0] NB = IW'(G_NB_REGS);
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {W_IDLE, W_WAIT_W, W_WAIT_AW, W_RESP} w_state_t;
    typedef enum logic {R_IDLE, R_RESP} r_state_t;

    logic [G_NB_REGS-1:0][DW-1:0] regs;

    // write path
    w_state_t       w_state, w_state_n;
    logic           awready_n, wready_n, bvalid_n;
    logic [1:0]     bresp_n;
    logic [AW-1:0]  aw_addr_q, aw_addr_n;
    logic [DW-1:0]  w_data_q, w_data_n;
    logic [SW-1:0]  w_strb_q, w_strb_n;
    logic           wr_en;
    logic [AW-1:0]  wr_addr;
    logic [DW-1:0]  wr_data;
    logic [SW-1:0]  wr_strb;
    logic [IW-1:0]  wr_idx;
    logic           aw_hs, w_hs;

    assign aw_hs  = awvalid & awready;
    assign w_hs   = wvalid & wready;
    assign wr_idx = wr_addr[AW-1:OFS];

    always_comb begin
        w_state_n = w_state;
        awready_n = awready;
        wready_n  = wready;
        bvalid_n  = bvalid;
        bresp_n   = bresp;
        aw_addr_n = aw_addr_q;
        w_data_n  = w_data_q;
        w_strb_n  = w_strb_q;
        wr_en     = 1'b0;
        wr_addr   = aw_addr_q;
        wr_data   = w_data_q;
        wr_strb   = w_strb_q;
        case (w_state)
            W_IDLE: begin
                awready_n = 1'b1;
                wready_n  = 1'b1;
                if (aw_hs && w_hs) begin
                    wr_en   = 1'b1;
                    wr_addr = awaddr;
                    wr_data = wdata;
                    wr_strb = wstrb;
                end else if (aw_hs) begin
                    aw_addr_n = awaddr;
                    awready_n = 1'b0;
                    w_state_n = W_WAIT_W;
                end else if (w_hs) begin
                    w_data_n  = wdata;
                    w_strb_n  = wstrb;
                    wready_n  = 1'b0;
                    w_state_n = W_WAIT_AW;
                end
            end
            W_WAIT_W: begin
                if (w_hs) begin
                    wr_en   = 1'b1;
                    wr_data = wdata;
                    wr_strb = wstrb;
                end
            end
            W_WAIT_AW: begin
                if (aw_hs) begin
                    wr_en   = 1'b1;
                    wr_addr = awaddr;
                end
            end
            W_RESP: begin
                if (bready) begin
                    bvalid_n  = 1'b0;
                    awready_n = 1'b1;
                    wready_n  = 1'b1;
                    w_state_n = W_IDLE;
                end
            end
            default: w_state_n = W_IDLE;
        endcase
        // Both halves of the write are now known: commit and respond next cycle.
        if (wr_en) begin
            awready_n = 1'b0;
            wready_n  = 1'b0;
            bvalid_n  = 1'b1;
            bresp_n   = (wr_addr[AW-1:OFS] < NB) ? RESP_OKAY : RESP_SLVERR;
            w_state_n = W_RESP;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            w_state   <= W_IDLE;
            awready   <= 1'b0;
            wready    <= 1'b0;
            bvalid    <= 1'b0;
            bresp     <= RESP_OKAY;
            aw_addr_q <= '0;
            w_data_q  <= '0;
            w_strb_q  <= '0;
        end else begin
            w_state   <= w_state_n;
            awready   <= awready_n;
            wready    <= wready_n;
            bvalid    <= bvalid_n;
            bresp     <= bresp_n;
            aw_addr_q <= aw_addr_n;
            w_data_q  <= w_data_n;
            w_strb_q  <= w_strb_n;
        end
    end

    // Out-of-range indices never match any i, so they modify nothing.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            regs <= '0;
        end else if (wr_en) begin
            for (int i = 0; i < G_NB_REGS; i++) begin
                if (wr_idx == IW'(i)) begin
                    for (int b = 0; b < SW; b++) begin
                        if (wr_strb[b]) regs[i][b*8 +: 8] <= wr_data[b*8 +: 8];
                    end
                end
            end
        end
    end

    assign regs_o = regs;

    // read path
    r_state_t       r_state, r_state_n;
    logic           arready_n, rvalid_n;
    logic [DW-1:0]  rdata_n, rd_val;
    logic [1:0]     rresp_n;
    logic [IW-1:0]  rd_idx;

    always_comb begin
        r_state_n = r_state;
        arready_n = arready;
        rvalid_n  = rvalid;
        rdata_n   = rdata;
        rresp_n   = rresp;
        rd_idx    = araddr[AW-1:OFS];
        rd_val    = '0;
        for (int i = 0; i < G_NB_REGS; i++) begin
            if (rd_idx == IW'(i)) rd_val = regs[i];
        end
        case (r_state)
            R_IDLE: begin
                arready_n = 1'b1;
                if (arvalid && arready) begin
                    arready_n = 1'b0;
                    rvalid_n  = 1'b1;
                    rdata_n   = rd_val;
                    rresp_n   = (rd_idx < NB) ? RESP_OKAY : RESP_SLVERR;
                    r_state_n = R_RESP;
                end
            end
            R_RESP: begin
                if (rready) begin
                    rvalid_n  = 1'b0;
                    arready_n = 1'b1;
                    r_state_n = R_IDLE;
                end
            end
            default: r_state_n = R_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= R_IDLE;
            arready <= 1'b0;
            rvalid  <= 1'b0;
            rdata   <= '0;
            rresp   <= RESP_OKAY;
        end else begin
            r_state <= r_state_n;
            arready <= arready_n;
            rvalid  <= rvalid_n;
            rdata   <= rdata_n;
            rresp   <= rresp_n;
        end
    end

    logic unused_ok;
    assign unused_ok = ^{awprot, arprot, wr_addr[OFS-1:0], araddr[OFS-1:0]};

endmodule
